lpc_record_serializer: RTL
==========================

LPC_RECORD_SERIALIZER -- requirements
Module: lpc_record_serializer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in 32-bit records; SHALL be a power of two, 2..64.
REQ-002 clk_i  input  1  LPC clock; all logic SHALL be rising-edge clocked.
REQ-003 nrst_i  input  1  reset, asynchronous, active-low.
REQ-004 tdata_i  input  32  cycle record from the LPC peripheral: [27:12] address, [11:4] data, [1:0] cycle type.
REQ-005 tvalid_i  input  1  single-cycle strobe; tdata_i is valid in the same cycle.
REQ-006 byte_o  output  8  serialized byte towards the UART/host link.
REQ-007 byte_valid_o  output  1  byte_o is valid.
REQ-008 byte_ready_i  input  1  sink accepts byte_o.
REQ-009 level_o  output  $clog2(DEPTH)+1  number of records currently in the FIFO.
REQ-010 overflow_o  output  1  sticky flag: a record was dropped.
REQ-011 ovf_clr_i  input  1  synchronous clear of overflow_o.

Function
REQ-012 Push: when tvalid_i=1 and the FIFO is not full, SHALL write tdata_i at the tail; level_o increments on the next edge.
REQ-013 Push when full: SHALL drop the record and set overflow_o on the next edge; FIFO contents are unchanged.
REQ-014 Full with a push and pop in the same cycle: SHALL accept the push; level_o stays at DEPTH.
REQ-015 ovf_clr_i and an overflowing push in the same cycle: SHALL leave overflow_o=1 (set wins).
REQ-016 FSM states: IDLE, LOAD, HDR, SEND.
- IDLE -> LOAD when level_o is nonzero.
- LOAD: pop the head into a 32-bit shift register and set byte index=0; -> HDR if the macro is defined, else -> SEND.
REQ-017 SEND SHALL present the bytes MSB first: [31:24], [23:16], [15:8], [7:0].
- Byte index advances only on byte_valid_o and byte_ready_i both 1.
- After byte 3 is accepted -> LOAD if the FIFO is non-empty, else -> IDLE.
REQ-018 Handshake: once byte_valid_o=1, byte_valid_o and byte_o SHALL stay stable until accepted; byte_valid_o SHALL NOT depend combinationally on byte_ready_i.
REQ-019 Latency: a record pushed at edge N into an empty, idle block SHALL give byte_valid_o=1 at edge N+2 (LOAD at N+1); back-to-back records SHALL add exactly one LOAD bubble cycle between frames.
REQ-020 Wrap-around: head and tail pointers SHALL wrap modulo DEPTH.
- Full = level_o equals DEPTH.
- Empty = level_o equals 0.
REQ-021 level_o SHALL count records still in the FIFO; the record being serialized SHALL NOT be counted.

Reset
REQ-022 While nrst_i=0, the following SHALL hold:
- state=IDLE, pointers=0, level_o=0;
- byte_valid_o=0, byte_o=0x00, overflow_o=0.
REQ-023 Reset mid-frame SHALL abort the frame; after reset release, no partial bytes of the aborted record SHALL be sent.
REQ-024 FIFO storage need not be reset.

Configuration
REQ-025 Macro LPC_SER_SYNC_BYTE_EN.
- Defined: each frame SHALL start with sync byte 0xA5 in state HDR, then 4 record bytes (5 bytes per frame).
- Undefined: HDR is unreachable; frames are 4 bytes.

Structure
REQ-026 Package lpc_ser_pkg SHALL hold the FSM state encoding, the SYNC_BYTE constant (0xA5) and the RECORD_BYTES constant (4).
REQ-027 The FIFO SHALL be a sub-module lpc_rec_fifo (push, pop, full, empty, level) instantiated once.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Single push of 0x0123_4567, byte_ready_i tied to 1, macro off -> bytes 0x01, 0x23, 0x45, 0x67 on four consecutive cycles starting at edge N+2; level_o returns to 0.
- Same push with the macro on -> bytes 0xA5, 0x01, 0x23, 0x45, 0x67.
- byte_ready_i=0 for 5 cycles during byte 1 -> byte_o holds 0x23 with byte_valid_o=1 throughout; no byte is skipped.
- DEPTH=8, sink stalled, 9 pushes -> level_o=8, overflow_o=1, the 9th record is never emitted; ovf_clr_i then clears the flag.
- Full FIFO with a push coinciding with LOAD -> push accepted, level_o stays 8, all 9 records emitted in order.
- nrst_i asserted after byte 2 -> byte_valid_o=0 immediately; after release with no new push, the block stays idle.

Source files
------------

// File: rtl/lpc_ser_pkg.sv
// rtl/lpc_ser_pkg.sv - shared FSM encoding and framing constants for the LPC record serializer
package lpc_ser_pkg;

  // Serializer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HDR  = 2'd2,
    ST_SEND = 2'd3
  } ser_state_t;

  // Frame marker sent ahead of each record when the sync byte build option is on
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Bytes per 32-bit cycle record
  localparam int RECORD_BYTES = 4;
  localparam int BYTE_IDX_W   = $clog2(RECORD_BYTES);

endpackage

// File: rtl/lpc_rec_fifo.sv
// rtl/lpc_rec_fifo.sv - 32-bit record FIFO with level count and drop indication
module lpc_rec_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic                     push_i,
  input  logic [31:0]              wdata_i,
  input  logic                     pop_i,
  output logic [31:0]              rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push_acc;
  logic          pop_acc;

  // A full FIFO still takes a push when the head leaves in the same cycle
  always_comb begin
    full_o   = (level_q == LW'(DEPTH));
    empty_o  = (level_q == '0);
    pop_acc  = pop_i && !empty_o;
    push_acc = push_i && (!full_o || pop_acc);
    drop_o   = push_i && !push_acc;
    rdata_o  = mem[rd_ptr_q];
    level_o  = level_q;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_acc) - LW'(pop_acc);
    end
  end

  // Storage is left unreset; only written entries are ever read
  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lpc_record_serializer.sv
// rtl/lpc_record_serializer.sv - buffers LPC cycle records and sends them MSB-first as bytes; LPC_SER_SYNC_BYTE_EN adds a 0xA5 frame marker
module lpc_record_serializer
  import lpc_ser_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic [31:0]              tdata_i,
  input  logic                     tvalid_i,
  output logic [7:0]               byte_o,
  output logic                     byte_valid_o,
  input  logic                     byte_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  input  logic                     ovf_clr_i
);

  ser_state_t              state_q;
  ser_state_t              state_d;
  logic [31:0]             shreg_q;
  logic [BYTE_IDX_W-1:0]   idx_q;
  logic                    pop;
  logic [31:0]             fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_drop;
  logic                    last_byte;

  lpc_rec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (tvalid_i),
    .wdata_i (tdata_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .level_o (level_o)
  );

  assign last_byte = (idx_q == BYTE_IDX_W'(RECORD_BYTES - 1));

  // State register; reset aborts any frame in flight
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; byte transfers complete on valid and ready together
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
`ifdef LPC_SER_SYNC_BYTE_EN
      ST_LOAD: state_d = ST_HDR;
`else
      ST_LOAD: state_d = ST_SEND;
`endif
      ST_HDR:  if (byte_ready_i) state_d = ST_SEND;
      ST_SEND: if (byte_ready_i && last_byte) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from the state register only, so valid never follows ready
  always_comb begin
    pop          = 1'b0;
    byte_valid_o = 1'b0;
    byte_o       = 8'h00;
    case (state_q)
      ST_LOAD: pop = 1'b1;
      ST_HDR: begin
        byte_valid_o = 1'b1;
        byte_o       = SYNC_BYTE;
      end
      ST_SEND: begin
        byte_valid_o = 1'b1;
        byte_o       = shreg_q[31:24];
      end
      default: ;
    endcase
  end

  // Record shifter: load the FIFO head, then shift one byte per accepted transfer
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (state_q == ST_LOAD) begin
      shreg_q <= fifo_rdata;
      idx_q   <= '0;
    end else if (state_q == ST_SEND && byte_ready_i) begin
      shreg_q <= {shreg_q[23:0], 8'h00};
      idx_q   <= idx_q + BYTE_IDX_W'(1);
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)        overflow_o <= 1'b0;
    else if (fifo_drop) overflow_o <= 1'b1;
    else if (ovf_clr_i) overflow_o <= 1'b0;
  end

  // Unused while the FIFO reports drops directly; kept for the full indication path
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
